// File: rtl/matrix_wb_pkg.sv
// Shared types, default widths and the sum-to-RAM-word extension for the matrix write-back.
package matrix_wb_pkg;

  localparam int unsigned DEF_NCH        = 4;
  localparam int unsigned DEF_SUM_W      = 20;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 13;
  localparam int unsigned DEF_STRIDE     = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned DEF_SIGNED     = 0;
  localparam int unsigned EXT_W          = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Keep the low sum_w bits; fill the rest with the field's top bit when sign_en is set.
  function automatic logic [EXT_W-1:0] extend_sum(input logic [EXT_W-1:0] sum,
                                                  input int unsigned      sum_w,
                                                  input logic             sign_en);
    logic [EXT_W-1:0] mask;
    logic             msb;
    mask = (sum_w >= EXT_W) ? '1 : ((EXT_W'(1) << sum_w) - EXT_W'(1));
    msb  = |(sum & mask & ~(mask >> 1));
    return (sum & mask) | ({EXT_W{sign_en & msb}} & ~mask);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Single-channel synchronous FIFO with a flush that empties it in one cycle.
module wb_fifo
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Pointers carry one extra lap bit to tell full from empty.
  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign dout_c  = mem_q[rd_q[PTR_W-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full_c) begin
        mem_d[wr_q[PTR_W-1:0]] = din;
        wr_d                   = wr_q + (PTR_W+1)'(1);
      end
      if (pop && !empty_c) begin
        rd_d = rd_q + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/wb_arb.sv
// Round-robin write-back of NCH channel sums onto one RAM write port with strided addressing.
module wb_arb
  import matrix_wb_pkg::*;
#(
  parameter int unsigned NCH        = DEF_NCH,
  parameter int unsigned SUM_W      = DEF_SUM_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned STRIDE     = DEF_STRIDE,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned SIGNED     = DEF_SIGNED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    total_words,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*SUM_W-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_data,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap,
  output logic                 overrun
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, cnt_q, cnt_d, total_q, total_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic              wrap_q, wrap_d, overrun_q, overrun_d, done_q, done_d, busy_q, busy_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;

  logic [NCH-1:0]    fifo_full, fifo_empty, push, pop;
  logic [SUM_W-1:0]  fifo_dout [NCH];
  logic              flush;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic [ADDR_W:0]   addr_sum;
  int unsigned       cand;

  assign in_ready = (state_q == ST_RUN) ? ~fifo_full : '0;
  assign push     = in_valid & in_ready;
  assign flush    = (state_q == ST_DONE);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SUM_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[i]),
      .pop     (pop[i]),
      .flush   (flush),
      .din     (in_data[i*SUM_W +: SUM_W]),
      .dout_c  (fifo_dout[i]),
      .full_c  (fifo_full[i]),
      .empty_c (fifo_empty[i])
    );
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_q;
    cand        = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = (32'(last_q) + k) % NCH;
      if (!grant_valid && !fifo_empty[CH_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
    grant_data = DATA_W'(extend_sum(EXT_W'(fifo_dout[grant_idx]), SUM_W, SIGNED != 0));
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    last_d     = last_q;
    wrap_d     = wrap_q;
    overrun_d  = overrun_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    done_d     = 1'b0;
    pop        = '0;
    addr_sum   = {1'b0, cur_addr_q} + (ADDR_W+1)'(STRIDE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d = base_addr;
          cnt_d      = '0;
          total_d    = total_words;
          wrap_d     = 1'b0;
          overrun_d  = 1'b0;
          state_d    = (total_words == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (grant_valid) begin
          pop[grant_idx] = 1'b1;
          ram_we_d       = 1'b1;
          ram_addr_d     = cur_addr_q;
          ram_data_d     = grant_data;
          cur_addr_d     = addr_sum[ADDR_W-1:0];
          wrap_d         = wrap_q | addr_sum[ADDR_W];
          cnt_d          = cnt_q + ADDR_W'(1);
          last_d         = grant_idx;
          if (cnt_q == total_q - ADDR_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        overrun_d = overrun_q | ~&fifo_empty;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      last_q     <= CH_W'(NCH - 1);
      wrap_q     <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      last_q     <= last_d;
      wrap_q     <= wrap_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: queue-level model checked every cycle plus hand-computed write logs.
module tb_wb_arb;

  localparam int unsigned NCH    = 4;
  localparam int unsigned SUM_W  = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned STRIDE = 4;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned AMOD   = 1 << ADDR_W;

  logic                 clk, rst, start;
  logic [ADDR_W-1:0]    base_addr, total_words;
  logic [NCH-1:0]       in_valid;
  logic [NCH*SUM_W-1:0] in_data;
  logic [NCH-1:0]       in_ready, s_in_ready;
  logic                 ram_we, s_ram_we, busy, s_busy, done, s_done;
  logic                 wrap, s_wrap, overrun, s_overrun;
  logic [ADDR_W-1:0]    ram_addr, s_ram_addr;
  logic [DATA_W-1:0]    ram_data, s_ram_data;

  wb_arb #(.NCH(NCH), .SUM_W(SUM_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRIDE(STRIDE),
           .FIFO_DEPTH(DEPTH), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_words(total_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy), .done(done), .wrap(wrap),
    .overrun(overrun));

  wb_arb #(.NCH(NCH), .SUM_W(SUM_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRIDE(STRIDE),
           .FIFO_DEPTH(DEPTH), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_words(total_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready), .ram_we(s_ram_we),
    .ram_addr(s_ram_addr), .ram_data(s_ram_data), .busy(s_busy), .done(s_done), .wrap(s_wrap),
    .overrun(s_overrun));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int               m_phase;  // 0 idle, 1 run, 2 done
  int unsigned      m_addr, m_cnt, m_tot, m_last, m_waddr;
  bit               m_wrap, m_ovr, m_done, m_we;
  logic [SUM_W-1:0] m_wsum;
  int               m_occ [NCH];
  logic [SUM_W-1:0] m_buf [NCH][DEPTH];
  bit               m_rdy [NCH];
  int               m_g;
  bit               m_found;

  function automatic logic [DATA_W-1:0] ext(input logic [SUM_W-1:0] s, input bit sgn);
    logic [DATA_W-1:0] r;
    r = DATA_W'(s);
    if (sgn && s[SUM_W-1]) r[DATA_W-1:SUM_W] = '1;
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_addr = 0; m_cnt = 0; m_tot = 0; m_last = NCH - 1; m_waddr = 0;
      m_wrap = 0; m_ovr = 0; m_done = 0; m_we = 0; m_wsum = '0;
      for (int c = 0; c < NCH; c++) m_occ[c] = 0;
    end else begin
      for (int c = 0; c < NCH; c++) m_rdy[c] = (m_phase == 1) && (m_occ[c] < DEPTH);
      m_we = 0;
      m_done = 0;
      case (m_phase)
        0: if (start) begin
          m_addr = base_addr; m_cnt = 0; m_tot = total_words; m_wrap = 0; m_ovr = 0;
          m_phase = (total_words == 0) ? 2 : 1;
        end
        1: begin
          m_found = 0; m_g = 0;
          for (int k = 1; k <= NCH; k++) begin
            if (!m_found && m_occ[(m_last + k) % NCH] > 0) begin
              m_found = 1; m_g = (m_last + k) % NCH;
            end
          end
          if (m_found) begin
            m_wsum = m_buf[m_g][0];
            for (int j = 0; j < DEPTH - 1; j++) m_buf[m_g][j] = m_buf[m_g][j+1];
            m_occ[m_g]--;
            m_we = 1; m_waddr = m_addr; m_addr += STRIDE;
            if (m_addr >= AMOD) begin m_addr -= AMOD; m_wrap = 1; end
            m_cnt++; m_last = m_g;
            if (m_cnt == m_tot) m_phase = 2;
          end
        end
        default: begin
          for (int c = 0; c < NCH; c++) begin
            if (m_occ[c] > 0) m_ovr = 1;
            m_occ[c] = 0;
          end
          m_done = 1; m_phase = 0;
        end
      endcase
      for (int c = 0; c < NCH; c++) begin
        if (m_rdy[c] && in_valid[c]) begin
          m_buf[c][m_occ[c]] = in_data[c*SUM_W +: SUM_W];
          m_occ[c]++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int               n_chk, n_fail, ncyc, wr_n, done_n, done_cyc, lit_rd;
  logic [ADDR_W-1:0] wr_addr [256];
  logic [DATA_W-1:0] wr_data [256], wr_sdata [256];
  int               wr_cyc [256];
  string            lit_nm [$];
  logic [63:0]      lit_act [$], lit_exp [$];
  logic [NCH-1:0]   exp_rdy;

  initial begin
    n_chk = 0; n_fail = 0; ncyc = 0; wr_n = 0; done_n = 0; done_cyc = 0; lit_rd = 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    for (int c = 0; c < NCH; c++) exp_rdy[c] = (m_phase == 1) && (m_occ[c] < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("ram_we", 64'(ram_we), 64'(m_we));
    chk("ram_addr", 64'(ram_addr), 64'(m_waddr));
    chk("ram_data", 64'(ram_data), 64'(ext(m_wsum, 0)));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("wrap", 64'(wrap), 64'(m_wrap));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("s_in_ready", 64'(s_in_ready), 64'(exp_rdy));
    chk("s_ram_we", 64'(s_ram_we), 64'(m_we));
    chk("s_ram_addr", 64'(s_ram_addr), 64'(m_waddr));
    chk("s_ram_data", 64'(s_ram_data), 64'(ext(m_wsum, 1)));
    chk("s_busy", 64'(s_busy), 64'(m_phase != 0));
    chk("s_done", 64'(s_done), 64'(m_done));
    chk("s_wrap", 64'(s_wrap), 64'(m_wrap));
    chk("s_overrun", 64'(s_overrun), 64'(m_ovr));
    if (ram_we && wr_n < 256) begin
      wr_addr[wr_n] = ram_addr; wr_data[wr_n] = ram_data; wr_sdata[wr_n] = s_ram_data;
      wr_cyc[wr_n] = ncyc; wr_n++;
    end
    if (done) begin done_n++; done_cyc = ncyc; end
    while (lit_rd < lit_nm.size()) begin
      chk(lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] e);
    lit_nm.push_back(nm); lit_act.push_back(a); lit_exp.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic put(input int ch, input logic [SUM_W-1:0] v);
    in_data[ch*SUM_W +: SUM_W] = v;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] t);
    start = 1'b1; base_addr = b; total_words = t;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!busy) break;
    end
    lit("idle_reached", 64'(busy), 64'(0));
  endtask

  task automatic lit_reset_vals();
    lit("rst_in_ready", 64'(in_ready), 64'(0));
    lit("rst_ram_we", 64'(ram_we), 64'(0));
    lit("rst_ram_addr", 64'(ram_addr), 64'(0));
    lit("rst_ram_data", 64'(ram_data), 64'(0));
    lit("rst_busy", 64'(busy), 64'(0));
    lit("rst_done", 64'(done), 64'(0));
    lit("rst_wrap", 64'(wrap), 64'(0));
    lit("rst_overrun", 64'(overrun), 64'(0));
  endtask

  int b, d0;

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; total_words = '0; in_valid = '0; in_data = '0;
    cyc();
    lit_reset_vals();
    rst = 1'b1;
    cyc();

    // four channels at once, data 1..4, written in channel order
    b = wr_n;
    do_start(13'h100, 13'd4);
    in_valid = 4'b1111; put(0, 20'd1); put(1, 20'd2); put(2, 20'd3); put(3, 20'd4);
    cyc();
    in_valid = '0;
    wait_idle();
    cyc();
    lit("t1_nwr", 64'(wr_n - b), 64'd4);
    for (int k = 0; k < 4; k++) begin
      lit("t1_addr", 64'(wr_addr[b+k]), 64'(13'h100 + 4 * k));
      lit("t1_data", 64'(wr_data[b+k]), 64'(k + 1));
    end
    lit("t1_done_lat", 64'(done_cyc - wr_cyc[b+3]), 64'd1);

    // sign versus zero extension of 0xFFFFF
    b = wr_n;
    do_start(13'h000, 13'd1);
    in_valid = 4'b0001; put(0, 20'hFFFFF);
    cyc();
    in_valid = '0;
    wait_idle();
    cyc();
    lit("t2_zext", 64'(wr_data[b]), 64'h0000_0000_000F_FFFF);
    lit("t2_sext", 64'(wr_sdata[b]), 64'h0000_0000_FFFF_FFFF);

    // channel 2 streaming continuously, one write per cycle
    b = wr_n;
    do_start(13'h200, 13'd6);
    in_valid = 4'b0100; put(2, 20'h12345);
    wait_idle();
    in_valid = '0;
    cyc();
    lit("t3_nwr", 64'(wr_n - b), 64'd6);
    lit("t3_span", 64'(wr_cyc[b+5] - wr_cyc[b]), 64'd5);
    for (int k = 0; k < 6; k++) lit("t3_data", 64'(wr_data[b+k]), 64'h12345);
    lit("t3_addr_last", 64'(wr_addr[b+5]), 64'h214);

    // address wrap past the top of the space; last grant was channel 2
    b = wr_n;
    do_start(13'h1FFC, 13'd2);
    in_valid = 4'b1111; put(0, 20'd5); put(1, 20'd6); put(2, 20'd7); put(3, 20'd8);
    cyc();
    in_valid = '0;
    wait_idle();
    cyc();
    lit("t4_addr0", 64'(wr_addr[b]), 64'h1FFC);
    lit("t4_data0", 64'(wr_data[b]), 64'd8);
    lit("t4_addr1", 64'(wr_addr[b+1]), 64'h0000);
    lit("t4_data1", 64'(wr_data[b+1]), 64'd5);
    lit("t4_wrap", 64'(wrap), 64'd1);
    lit("t4_mdl_wrap", 64'(m_wrap), 64'd1);

    // zero-length job goes straight to a done pulse
    b = wr_n; d0 = done_n;
    do_start(13'h010, 13'd0);
    wait_idle();
    cyc();
    lit("t0_nwr", 64'(wr_n - b), 64'd0);
    lit("t0_done", 64'(done_n - d0), 64'd1);

    // fresh arbiter: total 1, channels 0 and 1 push together
    rst = 1'b0; cyc(); rst = 1'b1; cyc();
    b = wr_n;
    do_start(13'h300, 13'd1);
    in_valid = 4'b0011; put(0, 20'h11); put(1, 20'h22);
    cyc();
    in_valid = '0;
    wait_idle();
    cyc();
    lit("t5_nwr", 64'(wr_n - b), 64'd1);
    lit("t5_data", 64'(wr_data[b]), 64'h11);
    lit("t5_overrun", 64'(overrun), 64'd1);
    lit("t5_mdl_ovr", 64'(m_ovr), 64'd1);

    // reset in mid-job after three writes, then a clean job
    b = wr_n;
    do_start(13'h040, 13'd8);
    in_valid = 4'b1111; put(0, 20'd1); put(1, 20'd2); put(2, 20'd3); put(3, 20'd4);
    cyc();
    put(0, 20'd5); put(1, 20'd6); put(2, 20'd7); put(3, 20'd8);
    cyc();
    in_valid = '0;
    cyc();
    cyc();
    @(negedge clk); #1;
    lit("t6_nwr_pre", 64'(wr_n - b), 64'd3);
    rst = 1'b0;
    #1;
    lit_reset_vals();
    cyc();
    rst = 1'b1;
    cyc();
    b = wr_n;
    do_start(13'h080, 13'd2);
    in_valid = 4'b0011; put(0, 20'h44); put(1, 20'h55);
    cyc();
    in_valid = '0;
    wait_idle();
    cyc();
    lit("t6_nwr", 64'(wr_n - b), 64'd2);
    lit("t6_addr0", 64'(wr_addr[b]), 64'h080);
    lit("t6_data0", 64'(wr_data[b]), 64'h44);
    lit("t6_addr1", 64'(wr_addr[b+1]), 64'h084);
    lit("t6_data1", 64'(wr_data[b+1]), 64'h55);
    lit("t6_wrap", 64'(wrap), 64'd0);
    lit("t6_overrun", 64'(overrun), 64'd0);

    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_arb.md
# wb_arb

Parametrised multi-channel write-back for the matrix datapath. It collects result sums from NCH processing channels through per-channel valid/ready buffers and arbitrates them round-robin onto a single RAM write port. Each sum is widened to the RAM word with sign or zero extension. It generates strided addresses from a programmable base, counts words to a programmed total, and reports completion, address wrap-around and overrun. It sits between the multiply-accumulate array and the result RAM.

## Interface
- NCH, 4, number of result channels (1..8)
- SUM_W, 20, result width per channel
- DATA_W, 32, RAM word width (≥ SUM_W)
- ADDR_W, 13, RAM byte-address width
- STRIDE, 4, address increment per written word
- FIFO_DEPTH, 2, entries per channel buffer (power of two, ≥ 2)
- SIGNED, 0, 1 = sign-extend sums, 0 = zero-extend
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; loads base_addr and total_words
- base_addr  in  ADDR_W  first write address
- total_words  in  ADDR_W  number of words to write in this job
- in_valid  in  NCH  per-channel sum valid
- in_data  in  NCH*SUM_W  channel i occupies bits [i*SUM_W +: SUM_W]
- in_ready  out  NCH  per-channel accept
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM write address (registered)
- ram_data  out  DATA_W  RAM write data (registered)
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- wrap  out  1  sticky: address wrapped past 2^ADDR_W during the job
- overrun  out  1  sticky: data was flushed at job end

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 0. On start, go to RUN. Load cur_addr = base_addr and cnt = 0. Clear wrap and overrun.
  - If start arrives with total_words = 0, go straight to DONE.
- RUN: in_ready[i] = !full[i]. The arbiter grants one non-empty channel per cycle, round-robin: search starts at last_grant+1 mod NCH.
  - Granted entry is popped and registered onto the RAM port with ram_we = 1, ram_addr = cur_addr, ram_data = extended sum.
  - Then cur_addr += STRIDE mod 2^ADDR_W; if this overflows, wrap is set. cnt increments.
  - When the write with cnt = total_words−1 issues, go to DONE.
- DONE: done = 1 for exactly one cycle. All FIFOs are flushed; if any was non-empty, overrun is set. Go to IDLE.
- start while RUN or DONE is ignored.
- A push and a pop on the same channel in the same cycle are both allowed; occupancy is unchanged.
- wrap and overrun hold until the next accepted start or reset.

## Timing
- Reset values: in_ready = 0, ram_we = 0, ram_addr = 0, ram_data = 0, busy = 0, done = 0, wrap = 0, overrun = 0. FIFOs are empty, last_grant = NCH−1, state = IDLE.
- busy = 1 in RUN and DONE.
- Latency: a sum accepted at edge t (FIFO previously empty, channel granted) appears on the RAM port after edge t+1.
- Throughput: one RAM write per cycle while any FIFO holds data.
- ram_we is low in every cycle in which no write issues. ram_addr and ram_data then hold their last values.
- The done pulse occurs in the cycle after the final write.
- Asserting reset in mid-job aborts immediately; no partial state survives.

## Structure
- Package matrix_wb_pkg: state encoding (IDLE/RUN/DONE), the extension function (SUM_W → DATA_W, keyed on SIGNED), and the default width constants.
- Sub-module wb_fifo: a single-channel synchronous FIFO (FIFO_DEPTH × SUM_W) with push, pop, flush, full and empty. It is instantiated NCH times.
- The arbiter, counters and output register live in wb_arb.

## Test plan
- Reset, then NCH = 4, base = 0x100, total = 4. Pulse in_valid on all channels simultaneously with data 1, 2, 3, 4.
  - Writes go to 0x100, 0x104, 0x108, 0x10C with data 1, 2, 3, 4 in channel order 0..3.
  - done pulses one cycle after the last write.
- SIGNED = 1, channel 0 sends 0xFFFFF → ram_data = 0xFFFFFFFF. With SIGNED = 0 the same input gives 0x000FFFFF.
- Channel 2 is held valid continuously, total = 6, FIFO_DEPTH = 2.
  - One write per cycle, all to channel 2's data.
  - in_ready[2] never drops while RUN; it drops in IDLE.
- base = 0x1FFC, total = 2 → writes go to 0x1FFC then 0x0000, and wrap = 1 after the job.
- total = 1, channels 0 and 1 both push in the same cycle.
  - Exactly one write, from channel 0.
  - DONE flushes channel 1, and overrun = 1.
- Reset asserted during RUN with 3 of 8 words written: all outputs return to reset values. A new start with total = 2 then completes normally from the new base.
